sram_1rw_fifo_ctrl: RTL and testbench



---
 rtl/sram_1rw_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_1rw_fifo_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_fifo_ctrl.sv
// FIFO controller in front of a single-port SRAM with a 2-entry prefetch staging buffer.
// Define SRAM_1RW_FIFO_BYPASS_EN to let pushes skip the SRAM when it and the read path are idle.
module sram_1rw_fifo_ctrl #(
   parameter int W = 32,
   parameter int N = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_valid,
   input  logic [W-1:0]           push_data,
   output logic                   push_ready,
   output logic                   pop_valid,
   output logic [W-1:0]           pop_data,
   input  logic                   pop_ready,
   output logic [$clog2(N)-1:0]   sram_addr,
   output logic [W-1:0]           sram_din,
   output logic                   sram_ce,
   output logic                   sram_oe,
   input  logic [W-1:0]           sram_dout,
   output logic [$clog2(N+3)-1:0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(N);
   localparam int MW = $clog2(N + 1);
   localparam int CW = $clog2(N + 3);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [MW-1:0] r_mem_cnt;
   logic          r_rd_inflight;
   logic [1:0]    r_stage_cnt;
   logic [W-1:0]  r_stage_head;
   logic [W-1:0]  r_stage_tail;

   logic [1:0]    w_occ;
   logic          w_rd_req;
   logic          w_rd_urgent;
   logic          w_full;
   logic          w_push_fire;
   logic          w_byp_ok;
   logic          w_byp_fire;
   logic          w_wr_fire;
   logic          w_rd_fire;
   logic          w_pop_fire;
   logic          w_stg_wr;
   logic [W-1:0]  w_stg_data;

   // Occupancy seen by the read scheduler: staged words plus the read whose data lands next cycle.
   assign w_occ       = r_stage_cnt + {1'b0, r_rd_inflight};
   assign w_rd_req    = (r_mem_cnt != '0) && (w_occ < 2'd2);
   assign w_rd_urgent = w_rd_req && (w_occ == 2'd0);
   assign w_full      = (r_mem_cnt == MW'(N));

   assign push_ready  = !rst && !w_full && !w_rd_urgent;
   assign w_push_fire = push_valid && push_ready;

`ifdef SRAM_1RW_FIFO_BYPASS_EN
   assign w_byp_ok    = (r_mem_cnt == '0) && !r_rd_inflight && (r_stage_cnt != 2'd2);
`else
   assign w_byp_ok    = 1'b0;
`endif

   assign w_byp_fire  = w_push_fire && w_byp_ok;
   assign w_wr_fire   = w_push_fire && !w_byp_ok;
   assign w_rd_fire   = !rst && w_rd_req && !w_wr_fire;

   assign pop_valid   = (r_stage_cnt != 2'd0);
   assign pop_data    = r_stage_head;
   assign w_pop_fire  = pop_valid && pop_ready;

   // Capture and bypass are mutually exclusive: bypass requires no read in flight.
   assign w_stg_wr    = r_rd_inflight || w_byp_fire;
   assign w_stg_data  = r_rd_inflight ? sram_dout : push_data;

   assign count = CW'(r_mem_cnt) + CW'(r_rd_inflight) + CW'(r_stage_cnt);
   assign full  = w_full;
   assign empty = (count == '0);

   always_comb begin
      sram_ce   = w_wr_fire || w_rd_fire;
      sram_oe   = w_rd_fire;
      sram_addr = w_rd_fire ? r_rd_ptr : r_wr_ptr;
      sram_din  = push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_mem_cnt     <= '0;
         r_rd_inflight <= 1'b0;
      end else begin
         if (w_wr_fire) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr_fire, w_rd_fire})
            2'b10:   r_mem_cnt <= r_mem_cnt + MW'(1);
            2'b01:   r_mem_cnt <= r_mem_cnt - MW'(1);
            default: r_mem_cnt <= r_mem_cnt;
         endcase
         r_rd_inflight <= w_rd_fire;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stage_cnt  <= 2'd0;
         r_stage_head <= '0;
         r_stage_tail <= '0;
      end else if (w_stg_wr && w_pop_fire) begin
         if (r_stage_cnt == 2'd1) begin
            r_stage_head <= w_stg_data;
         end else begin
            r_stage_head <= r_stage_tail;
            r_stage_tail <= w_stg_data;
         end
      end else if (w_stg_wr) begin
         if (r_stage_cnt == 2'd0) r_stage_head <= w_stg_data;
         else                     r_stage_tail <= w_stg_data;
         r_stage_cnt <= r_stage_cnt + 2'd1;
      end else if (w_pop_fire) begin
         r_stage_head <= r_stage_tail;
         r_stage_cnt  <= r_stage_cnt - 2'd1;
      end
   end

endmodule

// File: tb/tb_sram_1rw_fifo_ctrl.sv
// Scoreboard bench for sram_1rw_fifo_ctrl with a behavioural SRAM and randomized traffic.
// Honours SRAM_1RW_FIFO_BYPASS_EN for the latency-specific checks.
module tb_sram_1rw_fifo_ctrl;
   localparam int W  = 32;
   localparam int N  = 16;
   localparam int AW = $clog2(N);
   localparam int CW = $clog2(N + 3);

   logic          clk;
   logic          rst;
   logic          push_valid;
   logic [W-1:0]  push_data;
   logic          push_ready;
   logic          pop_valid;
   logic [W-1:0]  pop_data;
   logic          pop_ready;
   logic [AW-1:0] sram_addr;
   logic [W-1:0]  sram_din;
   logic          sram_ce;
   logic          sram_oe;
   logic [W-1:0]  sram_dout;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   sram_1rw_fifo_ctrl #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
      .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_ce(sram_ce), .sram_oe(sram_oe),
      .sram_dout(sram_dout), .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int model_cnt = 0;
   int stall_seen = 0;
   logic [W-1:0] sb_q[$];
   logic [W-1:0] mem [N];
   bit           vld [N];
   bit           prev_stall = 1'b0;
   bit           prev_hold = 1'b0;
   logic [W-1:0] prev_pd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Single-port SRAM: one access per cycle, read data registered.
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_oe) sram_dout <= mem[sram_addr];
         else         mem[sram_addr] <= sram_din;
      end
   end

   // Monitor: occupancy model, SRAM slot tracking, stall rule, and ordered scoreboard.
   always @(negedge clk) begin
      logic [W-1:0] exp_d;
      if (rst) begin
         sb_q.delete();
         model_cnt = 0;
         foreach (vld[i]) vld[i] = 1'b0;
         prev_stall = 1'b0;
         prev_hold  = 1'b0;
         chk("rst_ce", 64'(sram_ce), 64'd0);
         chk("rst_push_ready", 64'(push_ready), 64'd0);
         chk("rst_pop_valid", 64'(pop_valid), 64'd0);
         chk("rst_count", 64'(count), 64'd0);
      end else begin
         chk("count", 64'(count), 64'(model_cnt));
         chk("empty", 64'(empty), 64'(model_cnt == 0));
         if (prev_hold) chk("pop_hold", 64'(pop_data), 64'(prev_pd));
         if (prev_stall) chk("stall_len", 64'(push_ready), 64'd1);
         if (!push_ready && !full) begin
            stall_seen++;
            chk("stall_is_read", 64'(sram_ce && sram_oe), 64'd1);
         end
         prev_stall = !push_ready && !full;
         if (sram_ce && !sram_oe) begin
            chk("wr_from_push", 64'(push_valid && push_ready), 64'd1);
            chk("wr_din", 64'(sram_din), 64'(push_data));
            chk("wr_slot_free", 64'(vld[sram_addr]), 64'd0);
            vld[sram_addr] = 1'b1;
         end
         if (sram_ce && sram_oe) begin
            chk("rd_slot_used", 64'(vld[sram_addr]), 64'd1);
            vld[sram_addr] = 1'b0;
         end
         if (push_valid && push_ready) begin
            sb_q.push_back(push_data);
            model_cnt++;
         end
         if (pop_valid && pop_ready) begin
            if (sb_q.size() == 0) begin
               chk("pop_unexpected", 64'd1, 64'd0);
            end else begin
               exp_d = sb_q.pop_front();
               chk("pop_data", 64'(pop_data), 64'(exp_d));
            end
            model_cnt--;
         end
         prev_hold = pop_valid && !pop_ready;
         prev_pd   = pop_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input int maxc);
      bit ok = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (empty && sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
      chk("drain_done", 64'(ok), 64'd1);
   endtask

   task automatic push_one(input logic [W-1:0] d);
      bit ok = 1'b0;
      bit acc;
      push_valid = 1'b1;
      push_data  = d;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         acc = push_ready;
         tick();
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      push_valid = 1'b0;
      chk("push_accept", 64'(ok), 64'd1);
   endtask

   task automatic stream(input int nwords, input int pv, input int pr, input int maxc);
      int sent = 0;
      bit acc;
      push_valid = 1'b0;
      for (int c = 0; c < maxc && sent < nwords; c++) begin
         if (!push_valid && ($urandom_range(99) < pv)) begin
            push_valid = 1'b1;
            push_data  = W'($urandom);
         end
         pop_ready = ($urandom_range(99) < pr);
         @(negedge clk);
         acc = push_valid && push_ready;
         tick();
         if (acc) begin
            sent++;
            push_valid = 1'b0;
            if (sent < nwords && $urandom_range(99) < pv) begin
               push_valid = 1'b1;
               push_data  = W'($urandom);
            end
         end
      end
      push_valid = 1'b0;
      chk("stream_sent", 64'(sent), 64'(nwords));
   endtask

   initial begin
      int acc_n;
      int idle;
      int s0;
      bit acc;
      bit seen;
      rst = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_empty", 64'(empty), 64'd1);
         chk("idle_pop_valid", 64'(pop_valid), 64'd0);
         chk("idle_ce", 64'(sram_ce), 64'd0);
         chk("idle_push_ready", 64'(push_ready), 64'd1);
      end
      tick();

      // Single push: exact cycle-by-cycle latency
      push_valid = 1'b1; push_data = 32'hA5A5_0001; pop_ready = 1'b1;
      @(negedge clk);
      chk("sp_c0_ready", 64'(push_ready), 64'd1);
`ifdef SRAM_1RW_FIFO_BYPASS_EN
      chk("sp_c0_ce", 64'(sram_ce), 64'd0);
`else
      chk("sp_c0_ce", 64'(sram_ce), 64'd1);
      chk("sp_c0_oe", 64'(sram_oe), 64'd0);
      chk("sp_c0_addr", 64'(sram_addr), 64'd0);
      chk("sp_c0_din", 64'(sram_din), 64'hA5A5_0001);
`endif
      tick();
      push_valid = 1'b0;
      @(negedge clk);
`ifdef SRAM_1RW_FIFO_BYPASS_EN
      chk("sp_c1_ce", 64'(sram_ce), 64'd0);
      chk("sp_c1_pop_valid", 64'(pop_valid), 64'd1);
      chk("sp_c1_pop_data", 64'(pop_data), 64'hA5A5_0001);
`else
      chk("sp_c1_rd", 64'(sram_ce && sram_oe), 64'd1);
      chk("sp_c1_addr", 64'(sram_addr), 64'd0);
      chk("sp_c1_pop_valid", 64'(pop_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("sp_c2_pop_valid", 64'(pop_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("sp_c3_pop_valid", 64'(pop_valid), 64'd1);
      chk("sp_c3_pop_data", 64'(pop_data), 64'hA5A5_0001);
`endif
      tick();
      wait_empty(20);

      // Fill to capacity with the consumer stalled
      pop_ready = 1'b0; acc_n = 0; idle = 0;
      push_valid = 1'b1; push_data = '0;
      for (int c = 0; c < 400 && idle < 8; c++) begin
         @(negedge clk);
         acc = push_ready;
         tick();
         if (acc) begin
            acc_n++;
            idle = 0;
         end else begin
            idle++;
         end
         push_data = W'(acc_n);
      end
      chk("fill_accepted", 64'(acc_n), 64'(N + 2));
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_push_ready", 64'(push_ready), 64'd0);
      chk("fill_count", 64'(count), 64'(N + 2));
      push_valid = 1'b0;
      pop_ready  = 1'b1;
      wait_empty(200);
      chk("fill_empty_end", 64'(empty), 64'd1);

      // Continuous streaming across several pointer wraps
      stream(3 * N, 100, 100, 3000);
      pop_ready = 1'b1;
      wait_empty(200);

      // Contention: stage drained while SRAM still holds data
      pop_ready = 1'b0;
      stream(3, 100, 0, 200);
      repeat (6) tick();
      s0 = stall_seen;
      push_valid = 1'b1; push_data = W'($urandom); pop_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         acc = push_ready;
         tick();
         if (acc) push_data = W'($urandom);
      end
      push_valid = 1'b0;
      chk("contention_stall_seen", 64'(stall_seen > s0), 64'd1);
      wait_empty(200);

      // Randomized mixes
      stream(60, 50, 50, 4000);
      stream(60, 90, 30, 4000);
      stream(60, 40, 100, 4000);
      pop_ready = 1'b1;
      wait_empty(300);

      // Asynchronous reset with words held
      pop_ready = 1'b0;
      stream(5, 100, 0, 200);
      repeat (6) tick();
      chk("pre_rst_count", 64'(count), 64'd5);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_pop_valid", 64'(pop_valid), 64'd0);
      chk("async_rst_empty", 64'(empty), 64'd1);
      tick();
      tick();
      rst = 1'b0;
      pop_ready = 1'b1;
      push_one(32'h0000_1234);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (pop_valid && pop_ready) begin
            chk("post_rst_first", 64'(pop_data), 64'h1234);
            seen = 1'b1;
            break;
         end
      end
      chk("post_rst_pop_seen", 64'(seen), 64'd1);
      tick();
      wait_empty(50);
      chk("sb_empty_end", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
